rgb_to_ycbcr: RTL and testbench
===============================

RGB_TO_YCBCR -- requirements
Module: rgb_to_ycbcr

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning the bits per colour sample.
REQ-002 The block SHALL have parameter BLK_PIX, default 64, meaning the pixels per 8x8 block.
REQ-003 Port Clock: input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-004 Port reset: input, 1 bit; reset is synchronous and active-high.
REQ-005 Port Enable: input, 1 bit, start request; level-sensitive.
REQ-006 Ports R, G, B: input, 512 bits each, 8x8 block; pixel k=i*8+j (row i, column j) occupies bits [k*8 +: 8].
REQ-007 Ports Y, Cb, Cr: output reg, 512 bits each, converted block with the same pixel packing as REQ-006.
REQ-008 Port enable0: output reg, 1 bit, result-valid level that drives the Enable0 input of chrominance_downsampling.

Function
REQ-009 The FSM SHALL have states IDLE, CONV and DONE.
REQ-010 In IDLE with Enable=1 at a rising edge, the block SHALL capture R, G and B into internal block registers, clear the pixel counter k to 0, and enter CONV.
REQ-011 In CONV, the block SHALL convert pixel k from the captured copy each cycle, write it into Y, Cb and Cr at slot k, and increment k.
REQ-012 After writing k=BLK_PIX-1, the counter SHALL wrap to 0 and the FSM SHALL enter DONE.
REQ-013 In DONE, enable0 SHALL be 1; the block SHALL stay in DONE while Enable=1.
REQ-014 In DONE, when Enable=0 is sampled, the block SHALL return to IDLE with enable0=0 on the next cycle.
REQ-015 Latency: with Enable sampled high at edge 0, pixels SHALL be written at edges 1..64 and enable0 SHALL first read 1 after edge 65.
REQ-016 Input changes on R, G, B after the capture edge SHALL NOT affect the current block.
REQ-017 Enable deasserting during CONV SHALL be ignored; conversion SHALL complete and the FSM SHALL enter DONE, then leave DONE on the next edge because Enable=0.
REQ-018 Enable=1 held continuously SHALL NOT start a second block; a new block requires a return to IDLE first.
REQ-019 Y, Cb and Cr SHALL hold their last values in IDLE and DONE; in CONV, only slot k changes per cycle.
REQ-020 Arithmetic SHALL be Q8 signed using at least 18-bit intermediates:
 - Y = (77R + 150G + 29B + 128) >>> 8
 - Cb = ((-43R - 85G + 128B + 128) >>> 8) + 128
 - Cr = ((128R - 107G - 21B + 128) >>> 8) + 128
REQ-021 The shift SHALL be arithmetic (floor toward negative infinity).
REQ-022 Each result SHALL be clamped to 0..255 before truncation to 8 bits.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set state=IDLE, k=0, Y=Cb=Cr=0, enable0=0, and clear the captured block registers.
REQ-024 Reset SHALL take priority over Enable.
REQ-025 Reset asserted mid-CONV or in DONE SHALL abort the block with no partial result retained; the first Enable after reset release SHALL start a fresh block.

Structure
REQ-026 A shared package SHALL hold the coefficients (77, 150, 29, 43, 85, 128, 107, 21), the rounding constant 128, the offset 128, the FSM state encoding, and PIX_W/BLK_PIX defaults.
REQ-027 One combinational sub-module, ycbcr_pixel_conv, SHALL implement one pixel: 3x8-bit in, 3x8-bit out, covering REQ-020..REQ-022. It SHALL be instantiated once and indexed by k.

Verification
REQ-028 All pixels R=G=B=255, Enable held high -> Y=255, Cb=128, Cr=128 in every slot; enable0 rises after edge 65 and stays high.
REQ-029 All pixels R=255, G=B=0 -> Y=77, Cb=85, Cr=255 (clamped from 256); all pixels B=255, R=G=0 -> Y=29, Cb=255 (clamped), Cr=107.
REQ-030 All-zero block -> Y=0, Cb=128, Cr=128; a ramp block R=G=B=k -> Y slot k equals k, Cb=Cr=128.
REQ-031 Enable pulsed for one cycle, R/G/B changed on the next cycle -> output matches the captured block; enable0 high for exactly 1 cycle, then IDLE.
REQ-032 reset asserted at edge 30 of CONV -> next cycle all outputs 0, enable0=0; a new Enable yields a correct full block after 65 edges.
REQ-033 Chain with chrominance_downsampling -> its Cb_d and Cr_d equal the 2x2 averages of this block's Cb and Cr.

Source files
------------

// File: rtl/rgb_to_ycbcr_pkg.sv
// Shared constants for the RGB to YCbCr block converter: Q8 coefficients,
// rounding/offset constants, FSM encoding and default geometry.
package rgb_to_ycbcr_pkg;

   localparam int unsigned PixWDefault   = 8;
   localparam int unsigned BlkPixDefault = 64;

   // Q8 coefficients; signs are applied at the point of use.
   localparam int CoefYR  = 77;
   localparam int CoefYG  = 150;
   localparam int CoefYB  = 29;
   localparam int CoefCbR = 43;
   localparam int CoefCbG = 85;
   localparam int CoefCbB = 128;
   localparam int CoefCrR = 128;
   localparam int CoefCrG = 107;
   localparam int CoefCrB = 21;

   localparam int RoundConst  = 128;
   localparam int ChromaOffset = 128;
   localparam int FracBits    = 8;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StConv = 2'd1;
   localparam state_t StDone = 2'd2;

endpackage

// File: rtl/ycbcr_pixel_conv.sv
// Single-pixel RGB to YCbCr conversion: Q8 multiply-accumulate, arithmetic
// shift, chroma offset and saturation to the unsigned sample range.
module ycbcr_pixel_conv
   import rgb_to_ycbcr_pkg::*;
#(
   parameter int unsigned PIX_W = PixWDefault
) (
   input  logic [PIX_W-1:0] r_i,
   input  logic [PIX_W-1:0] g_i,
   input  logic [PIX_W-1:0] b_i,
   output logic [PIX_W-1:0] y_o,
   output logic [PIX_W-1:0] cb_o,
   output logic [PIX_W-1:0] cr_o
);

   // Headroom for 256 * max sample plus rounding, with a sign bit.
   localparam int unsigned AccW = PIX_W + 10;

   localparam logic signed [AccW-1:0] KYR  = AccW'(CoefYR);
   localparam logic signed [AccW-1:0] KYG  = AccW'(CoefYG);
   localparam logic signed [AccW-1:0] KYB  = AccW'(CoefYB);
   localparam logic signed [AccW-1:0] KCbR = AccW'(CoefCbR);
   localparam logic signed [AccW-1:0] KCbG = AccW'(CoefCbG);
   localparam logic signed [AccW-1:0] KCbB = AccW'(CoefCbB);
   localparam logic signed [AccW-1:0] KCrR = AccW'(CoefCrR);
   localparam logic signed [AccW-1:0] KCrG = AccW'(CoefCrG);
   localparam logic signed [AccW-1:0] KCrB = AccW'(CoefCrB);
   localparam logic signed [AccW-1:0] KRnd = AccW'(RoundConst);
   localparam logic signed [AccW-1:0] KOff = AccW'(ChromaOffset);
   localparam logic signed [AccW-1:0] KMax = AccW'((1 << PIX_W) - 1);

   logic signed [AccW-1:0] r_s, g_s, b_s;
   logic signed [AccW-1:0] y_acc, cb_acc, cr_acc;
   logic signed [AccW-1:0] y_val, cb_val, cr_val;

   function automatic logic [PIX_W-1:0] sat(input logic signed [AccW-1:0] v);
      if (v[AccW-1]) begin
         return '0;
      end else if (v > KMax) begin
         return '1;
      end else begin
         return v[PIX_W-1:0];
      end
   endfunction

   always_comb begin
      r_s = signed'(AccW'(r_i));
      g_s = signed'(AccW'(g_i));
      b_s = signed'(AccW'(b_i));

      y_acc  = r_s * KYR + g_s * KYG + b_s * KYB + KRnd;
      cb_acc = b_s * KCbB - r_s * KCbR - g_s * KCbG + KRnd;
      cr_acc = r_s * KCrR - g_s * KCrG - b_s * KCrB + KRnd;

      // >>> floors toward negative infinity on the signed accumulators.
      y_val  = y_acc >>> FracBits;
      cb_val = (cb_acc >>> FracBits) + KOff;
      cr_val = (cr_acc >>> FracBits) + KOff;

      y_o  = sat(y_val);
      cb_o = sat(cb_val);
      cr_o = sat(cr_val);
   end

endmodule

// File: rtl/rgb_to_ycbcr.sv
// 8x8 block RGB to YCbCr converter: captures a block on Enable, converts one
// pixel per cycle and raises enable0 once the whole block is written.
module rgb_to_ycbcr
   import rgb_to_ycbcr_pkg::*;
#(
   parameter int unsigned PIX_W   = PixWDefault,
   parameter int unsigned BLK_PIX = BlkPixDefault
) (
   input  logic                     Clock,
   input  logic                     reset,
   input  logic                     Enable,
   input  logic [PIX_W*BLK_PIX-1:0] R,
   input  logic [PIX_W*BLK_PIX-1:0] G,
   input  logic [PIX_W*BLK_PIX-1:0] B,
   output logic [PIX_W*BLK_PIX-1:0] Y,
   output logic [PIX_W*BLK_PIX-1:0] Cb,
   output logic [PIX_W*BLK_PIX-1:0] Cr,
   output logic                     enable0
);

   localparam int unsigned BlkW = PIX_W * BLK_PIX;
   localparam int unsigned KW   = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
   localparam logic [KW-1:0] KLast = KW'(BLK_PIX - 1);

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [BlkW-1:0] r_q, g_q, b_q;
   logic            capture;

   logic [PIX_W-1:0] r_pix, g_pix, b_pix;
   logic [PIX_W-1:0] y_pix, cb_pix, cr_pix;

   // Pixel source is always the captured copy, never the live inputs.
   assign r_pix = r_q[k_q*PIX_W +: PIX_W];
   assign g_pix = g_q[k_q*PIX_W +: PIX_W];
   assign b_pix = b_q[k_q*PIX_W +: PIX_W];

   ycbcr_pixel_conv #(
      .PIX_W (PIX_W)
   ) u_pixel_conv (
      .r_i  (r_pix),
      .g_i  (g_pix),
      .b_i  (b_pix),
      .y_o  (y_pix),
      .cb_o (cb_pix),
      .cr_o (cr_pix)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      capture = 1'b0;
      case (state_q)
         StIdle: begin
            if (Enable) begin
               state_d = StConv;
               k_d     = '0;
               capture = 1'b1;
            end
         end
         StConv: begin
            if (k_q == KLast) begin
               k_d     = '0;
               state_d = StDone;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StDone: begin
            if (!Enable) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            k_d     = '0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         Y       <= '0;
         Cb      <= '0;
         Cr      <= '0;
         enable0 <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         // Registered from the current state, so it trails DONE entry by a cycle.
         enable0 <= (state_q == StDone);
         if (capture) begin
            r_q <= R;
            g_q <= G;
            b_q <= B;
         end
         if (state_q == StConv) begin
            Y[k_q*PIX_W +: PIX_W]  <= y_pix;
            Cb[k_q*PIX_W +: PIX_W] <= cb_pix;
            Cr[k_q*PIX_W +: PIX_W] <= cr_pix;
         end
      end
   end

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// Directed bench for rgb_to_ycbcr: uniform, ramp and mixed blocks with
// hand-computed results, latency, Enable handling and mid-block reset.
module tb_rgb_to_ycbcr;

   logic         Clock;
   logic         reset;
   logic         Enable;
   logic [511:0] R, G, B;
   logic [511:0] Y, Cb, Cr;
   logic         enable0;

   int n_vec = 0;
   int n_err = 0;

   rgb_to_ycbcr dut (
      .Clock   (Clock),
      .reset   (reset),
      .Enable  (Enable),
      .R       (R),
      .G       (G),
      .B       (B),
      .Y       (Y),
      .Cb      (Cb),
      .Cr      (Cr),
      .enable0 (enable0)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] fill(input logic [7:0] v);
      logic [511:0] f;
      for (int i = 0; i < 64; i++) f[i*8 +: 8] = v;
      return f;
   endfunction

   function automatic logic [511:0] ramp();
      logic [511:0] f;
      for (int i = 0; i < 64; i++) f[i*8 +: 8] = 8'(i);
      return f;
   endfunction

   // Even pixels take value a, odd pixels value b.
   function automatic logic [511:0] alt(input logic [7:0] a, input logic [7:0] b);
      logic [511:0] f;
      for (int i = 0; i < 64; i++) f[i*8 +: 8] = i[0] ? b : a;
      return f;
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Starts a block from IDLE and waits (bounded) for enable0.
   task automatic run_block(input logic [511:0] r, input logic [511:0] g, input logic [511:0] b,
                            input bit hold, input bit scramble);
      int lat;
      R = r;
      G = g;
      B = b;
      Enable = 1'b1;
      tick();
      if (!hold) Enable = 1'b0;
      if (scramble) begin
         R = ~r;
         G = ~g ^ {64{8'h5a}};
         B = ~b;
      end
      lat = 0;
      while (!enable0 && lat < 100) begin
         tick();
         lat++;
      end
      check("latency", 512'(lat), 512'd65);
   endtask

   task automatic check_block(input string tag, input logic [511:0] ey, input logic [511:0] ecb,
                              input logic [511:0] ecr);
      check({tag, ".Y"}, Y, ey);
      check({tag, ".Cb"}, Cb, ecb);
      check({tag, ".Cr"}, Cr, ecr);
   endtask

   initial begin
      reset  = 1'b1;
      Enable = 1'b0;
      R = '0;
      G = '0;
      B = '0;
      repeat (3) tick();
      check_block("reset", '0, '0, '0);
      check("reset.enable0", 512'(enable0), 512'd0);
      reset = 1'b0;
      tick();

      // White, Enable held high throughout.
      run_block(fill(8'd255), fill(8'd255), fill(8'd255), 1'b1, 1'b0);
      check_block("white", fill(8'd255), fill(8'd128), fill(8'd128));
      R = '0;
      repeat (70) tick();
      check("hold.enable0", 512'(enable0), 512'd1);
      check("hold.no_restart", Y, fill(8'd255));
      Enable = 1'b0;
      repeat (2) tick();
      check("hold.release", 512'(enable0), 512'd0);

      // Red, one-cycle pulse with inputs scrambled after capture.
      run_block(fill(8'd255), fill(8'd0), fill(8'd0), 1'b0, 1'b1);
      check_block("red", fill(8'd77), fill(8'd85), fill(8'd255));
      tick();
      check("red.pulse_width", 512'(enable0), 512'd0);
      repeat (3) tick();
      check("red.idle_hold", Cr, fill(8'd255));

      run_block(fill(8'd0), fill(8'd0), fill(8'd255), 1'b0, 1'b1);
      check_block("blue", fill(8'd29), fill(8'd255), fill(8'd107));
      tick();
      check("blue.pulse_width", 512'(enable0), 512'd0);

      run_block(fill(8'd0), fill(8'd0), fill(8'd0), 1'b0, 1'b0);
      check_block("zero", fill(8'd0), fill(8'd128), fill(8'd128));
      tick();

      run_block(ramp(), ramp(), ramp(), 1'b0, 1'b1);
      check_block("ramp", ramp(), fill(8'd128), fill(8'd128));
      tick();

      // (100,50,200) -> (82,195,141); (10,200,30) -> (124,75,47).
      run_block(alt(8'd100, 8'd10), alt(8'd50, 8'd200), alt(8'd200, 8'd30), 1'b0, 1'b0);
      check_block("mixed", alt(8'd82, 8'd124), alt(8'd195, 8'd75), alt(8'd141, 8'd47));
      tick();

      // Reset at edge 30 of a conversion, then a fresh block.
      R = fill(8'd255);
      G = fill(8'd255);
      B = fill(8'd255);
      Enable = 1'b1;
      tick();
      Enable = 1'b0;
      repeat (29) tick();
      reset = 1'b1;
      tick();
      check_block("abort", '0, '0, '0);
      check("abort.enable0", 512'(enable0), 512'd0);
      reset = 1'b0;
      tick();
      run_block(alt(8'd10, 8'd100), alt(8'd200, 8'd50), alt(8'd30, 8'd200), 1'b0, 1'b1);
      check_block("restart", alt(8'd124, 8'd82), alt(8'd75, 8'd195), alt(8'd47, 8'd141));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
